loba_seq_ctrl: RTL and testbench

LOBA_SEQ_CTRL -- requirements
Module: loba_seq_ctrl

---
 rtl/loba_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_loba_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loba_seq_ctrl.sv
// loba_seq_ctrl: sequential LOBA (leading-one based) approximate multiplier.
// Each operand is reduced to two K-bit segments taken from its leading
// ones. The product of the segments is built one term per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready request handshake (ready only while idle)
//   a [NA], b [NB]      operands, captured on accept
//   mode [2]            number of extra partial-product terms (0..3)
//   out_valid/out_ready result handshake
//   r [NA+NB]           approximate product, held after hand-off
//   busy                high whenever the block is not idle
//
// Build option: define LOBA_SEQ_SIGNED_EN for two's-complement operands.
// Without it, a, b and r are unsigned and no sign logic exists.
module loba_seq_ctrl #(
    parameter int K  = 4,
    parameter int NA = 16,
    parameter int NB = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NA-1:0]    a,
    input  logic [NB-1:0]    b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NA+NB-1:0] r,
    output logic             busy
);

    localparam int W  = NA + NB;
    localparam int NM = (NA > NB) ? NA : NB;
    localparam int KW = $clog2(NM);
    localparam int SW = $clog2(W) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPLIT = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [NA-1:0] a_q;
    logic [NB-1:0] b_q;
    logic [1:0]    mode_q;
    logic [1:0]    cnt;
    logic [W-1:0]  acc;
    logic [K-1:0]  ah, al, bh, bl;
    logic [KW-1:0] kha, kla, khb, klb;
`ifdef LOBA_SEQ_SIGNED_EN
    logic          neg_q;
`endif

    // Index of the leading one, never below K-1 so a full
    // K-bit window always fits under it.
    function automatic logic [KW-1:0] top_idx(
        input logic [NM-1:0] x
    );
        logic [KW-1:0] k;
        k = KW'(K-1);
        for (int i = K; i < NM; i++) begin
            if (x[i]) k = KW'(i);
        end
        return k;
    endfunction

    // K-bit window ending at bit k.
    function automatic logic [K-1:0] seg(
        input logic [NM-1:0] x,
        input logic [KW-1:0] k
    );
        return K'(x >> (k - KW'(K-1)));
    endfunction

    // Bits strictly below the window ending at bit k.
    function automatic logic [NM-1:0] low_part(
        input logic [NM-1:0] x,
        input logic [KW-1:0] k
    );
        logic [NM-1:0] m;
        m = (NM'(1) << (k - KW'(K-1))) - NM'(1);
        return x & m;
    endfunction

    // Segment extraction for the captured operands.
    logic [NM-1:0] xa, xb, la, lb;
    logic [KW-1:0] kha_c, kla_c, khb_c, klb_c;

    always_comb begin
        xa    = NM'(a_q);
        xb    = NM'(b_q);
        kha_c = top_idx(xa);
        khb_c = top_idx(xb);
        la    = low_part(xa, kha_c);
        lb    = low_part(xb, khb_c);
        kla_c = top_idx(la);
        klb_c = top_idx(lb);
    end

    // Current term: cnt[1] picks the a segment, cnt[0] the b segment,
    // giving the order hh, hl, lh, ll.
    logic [K-1:0]   pa, pb;
    logic [KW-1:0]  ka, kb;
    logic [2*K-1:0] prod;
    logic [SW-1:0]  sh;
    logic [W-1:0]   term;
    logic [W-1:0]   sum;
    logic [W-1:0]   fin;

    always_comb begin
        pa   = cnt[1] ? al  : ah;
        ka   = cnt[1] ? kla : kha;
        pb   = cnt[0] ? bl  : bh;
        kb   = cnt[0] ? klb : khb;
        prod = {{K{1'b0}}, pa} * {{K{1'b0}}, pb};
        sh   = SW'(ka) + SW'(kb) - SW'(2*(K-1));
        term = W'(prod) << sh;
        sum  = acc + term;
`ifdef LOBA_SEQ_SIGNED_EN
        fin  = neg_q ? (~sum + W'(1)) : sum;
`else
        fin  = sum;
`endif
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            cnt    <= '0;
            acc    <= '0;
            ah     <= '0;
            al     <= '0;
            bh     <= '0;
            bl     <= '0;
            kha    <= '0;
            kla    <= '0;
            khb    <= '0;
            klb    <= '0;
            r      <= '0;
`ifdef LOBA_SEQ_SIGNED_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef LOBA_SEQ_SIGNED_EN
                        // Most negative value maps to 2^(N-1),
                        // which still fits as an unsigned magnitude.
                        a_q   <= a[NA-1] ? (~a + NA'(1)) : a;
                        b_q   <= b[NB-1] ? (~b + NB'(1)) : b;
                        neg_q <= a[NA-1] ^ b[NB-1];
`else
                        a_q   <= a;
                        b_q   <= b;
`endif
                        mode_q <= mode;
                        state  <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    ah    <= seg(xa, kha_c);
                    al    <= seg(la, kla_c);
                    bh    <= seg(xb, khb_c);
                    bl    <= seg(lb, klb_c);
                    kha   <= kha_c;
                    kla   <= kla_c;
                    khb   <= khb_c;
                    klb   <= klb_c;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= S_ACC;
                end
                S_ACC: begin
                    acc <= sum;
                    cnt <= cnt + 2'd1;
                    if (cnt == mode_q) begin
                        r     <= fin;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_loba_seq_ctrl.sv
// tb_loba_seq_ctrl: directed bench for loba_seq_ctrl with an
// arithmetic reference model checked every cycle.
module tb_loba_seq_ctrl;

    localparam int K  = 4;
    localparam int NA = 16;
    localparam int NB = 16;
    localparam int W  = NA + NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NA-1:0] a;
    logic [NB-1:0] b;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  r;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loba_seq_ctrl #(.K(K), .NA(NA), .NB(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .busy      (busy)
    );

    task automatic chk(input string name,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Leading-one position by repeated halving; -1 for zero.
    function automatic int lead(input longint unsigned x);
        int m;
        longint unsigned t;
        m = -1;
        t = x;
        while (t != 0) begin
            m++;
            t = t / 2;
        end
        return m;
    endfunction

    function automatic void split_m(input longint unsigned x,
                                    output longint unsigned hi,
                                    output longint unsigned lo,
                                    output int kh,
                                    output int kl);
        longint unsigned base, l;
        int m;
        m    = lead(x);
        kh   = (m > K-1) ? m : K-1;
        base = 64'd1 << (kh-K+1);
        hi   = (x / base) % (64'd1 << K);
        l    = x % base;
        m    = lead(l);
        kl   = (m > K-1) ? m : K-1;
        base = 64'd1 << (kl-K+1);
        lo   = (l / base) % (64'd1 << K);
    endfunction

    function automatic logic [W-1:0] expect_r(input logic [NA-1:0] aa,
                                              input logic [NB-1:0] bb,
                                              input logic [1:0] mm);
        longint unsigned ma, mb, ahv, alv, bhv, blv, pa, pb, s, md;
        int kha, kla, khb, klb, ka, kb;
        bit neg;
        ma  = aa;
        mb  = bb;
        neg = 1'b0;
`ifdef LOBA_SEQ_SIGNED_EN
        if (aa[NA-1]) ma = (64'd1 << NA) - aa;
        if (bb[NB-1]) mb = (64'd1 << NB) - bb;
        neg = aa[NA-1] ^ bb[NB-1];
`endif
        split_m(ma, ahv, alv, kha, kla);
        split_m(mb, bhv, blv, khb, klb);
        md = 64'd1 << W;
        s  = 0;
        for (int i = 0; i <= int'(mm); i++) begin
            pa = (i >= 2) ? alv : ahv;
            ka = (i >= 2) ? kla : kha;
            pb = (i % 2 == 1) ? blv : bhv;
            kb = (i % 2 == 1) ? klb : khb;
            s  = s + pa * pb * (64'd1 << (ka + kb - 2*(K-1)));
        end
        s = s % md;
        if (neg) s = (md - s) % md;
        return s[W-1:0];
    endfunction

    // Transaction-level model: after an accept the result appears
    // 2+mode edges later and stays until taken.
    logic         m_busy = 1'b0;
    logic         m_vld  = 1'b0;
    logic [W-1:0] m_r    = '0;
    logic [W-1:0] m_exp  = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_vld  <= 1'b0;
            m_r    <= '0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_left <= 2 + int'(mode);
                m_exp  <= expect_r(a, b, mode);
            end
        end else if (m_vld) begin
            if (out_ready) begin
                m_vld  <= 1'b0;
                m_busy <= 1'b0;
            end
        end else begin
            if (m_left == 1) begin
                m_vld <= 1'b1;
                m_r   <= m_exp;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", in_ready, !m_busy);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_out_valid", out_valid, m_vld);
        chk("cyc_r", r, m_r);
    end

    task automatic run(input logic [NA-1:0] ta,
                       input logic [NB-1:0] tb,
                       input logic [1:0] tm,
                       input logic [W-1:0] exp,
                       input bit lit);
        int n;
        @(negedge clk);
        a        = ta;
        b        = tb;
        mode     = tm;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        mode     = 2'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", W'(n), W'(2 + int'(tm)));
        if (lit) chk("result", r, exp);
    endtask

    int n;
    logic [W-1:0] held;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        mode      = '0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_r", r, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifndef LOBA_SEQ_SIGNED_EN
        chk("model_1000_m1", expect_r(16'd1000, 16'd1000, 2'd1),
            32'd960000);
        chk("model_255_3_m2", expect_r(16'd255, 16'd3, 2'd2), 32'd765);
`endif

        run(16'd255, 16'd3, 2'd0, 32'd720, 1'b1);
        run(16'd255, 16'd3, 2'd2, 32'd765, 1'b1);
        run(16'd1000, 16'd1000, 2'd0, 32'd921600, 1'b1);
        run(16'd1000, 16'd1000, 2'd1, 32'd960000, 1'b1);
        run(16'd1000, 16'd1000, 2'd2, 32'd998400, 1'b1);
        run(16'd1000, 16'd1000, 2'd3, 32'd1000000, 1'b1);
        run(16'd0, 16'd1234, 2'd1, 32'd0, 1'b1);
        run(16'd5678, 16'd0, 2'd3, 32'd0, 1'b1);
        run(16'd0, 16'd0, 2'd2, 32'd0, 1'b1);
`ifdef LOBA_SEQ_SIGNED_EN
        run(16'hFC18, 16'd1000, 2'd3, 32'hFFF0BDC0, 1'b1);
        run(16'hFC18, 16'hFC18, 2'd3, 32'd1000000, 1'b1);
`else
        run(16'hFFFF, 16'hFFFF, 2'd3, 32'd4261478400, 1'b1);
        run(16'd7, 16'd5, 2'd3, 32'd35, 1'b1);
`endif
        for (int i = 0; i < 6; i++) begin
            run(16'($urandom), 16'($urandom),
                2'($urandom_range(0, 3)), '0, 1'b0);
        end

        // Consumer stall: result must hold, new requests ignored.
        @(negedge clk);
        out_ready = 1'b0;
        a         = 16'd1000;
        b         = 16'd1000;
        mode      = 2'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", out_valid, 1'b1);
        chk("stall_r", r, 32'd960000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i < 5);
            a        = 16'h1234;
            chk("stall_hold_valid", out_valid, 1'b1);
            chk("stall_hold_r", r, 32'd960000);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", out_valid, 1'b0);
        chk("release_ready", in_ready, 1'b1);
        chk("release_r", r, 32'd960000);

        // Reset while accumulating discards the operation.
        @(negedge clk);
        a        = 16'd1000;
        b        = 16'd1000;
        mode     = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_r", r, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", out_valid, 1'b0);
        end
        run(16'd1000, 16'd1000, 2'd3, 32'd1000000, 1'b1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
